// File: rtl/seq_restoring_divider_if.sv
// Start/operand request and result/status bundle for the sequential divider.
interface seq_restoring_divider_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider producing one quotient bit per clock,
// started by a level Start that must drop before the next request.
module seq_restoring_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   seq_restoring_divider_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] quo, quo_nxt;
   logic [WIDTH-1:0] rem, rem_nxt;
   logic [WIDTH-1:0] dvs, dvs_nxt;
   logic             dbz, dbz_nxt;
   logic             busy_q, done_q;
   logic [WIDTH:0]   p, t;

   // State and datapath registers; busy/done track the next state so they
   // are flops that mirror the state register exactly.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
         dbz    <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         quo    <= quo_nxt;
         rem    <= rem_nxt;
         dvs    <= dvs_nxt;
         dbz    <= dbz_nxt;
         busy_q <= (state_nxt == CALC);
         done_q <= (state_nxt == DONE);
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      quo_nxt   = quo;
      rem_nxt   = rem;
      dvs_nxt   = dvs;
      dbz_nxt   = dbz;
      // The trial keeps a borrow bit above the shifted remainder.
      p         = {rem, quo[WIDTH-1]};
      t         = p - {1'b0, dvs};

      case (state)
         IDLE: begin
            if (bus.start) begin
               dvs_nxt = bus.divisor;
               cnt_nxt = '0;
               if (bus.divisor == '0) begin
                  quo_nxt   = '1;
                  rem_nxt   = bus.dividend;
                  dbz_nxt   = 1'b1;
                  state_nxt = DONE;
               end else begin
                  quo_nxt   = bus.dividend;
                  rem_nxt   = '0;
                  dbz_nxt   = 1'b0;
                  state_nxt = CALC;
               end
            end
         end
         CALC: begin
            if (!t[WIDTH]) begin
               rem_nxt = t[WIDTH-1:0];
               quo_nxt = {quo[WIDTH-2:0], 1'b1};
            end else begin
               rem_nxt = p[WIDTH-1:0];
               quo_nxt = {quo[WIDTH-2:0], 1'b0};
            end
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (!bus.start) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.quotient    = quo;
   assign bus.remainder   = rem;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized self-checking bench for seq_restoring_divider against a plain
// integer division model.
module tb_seq_restoring_divider;
   localparam int unsigned WIDTH = 8;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_restoring_divider #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs driven and outputs sampled 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_quo(input int a, input int b);
      return (b == 0) ? (1 << WIDTH) - 1 : a / b;
   endfunction

   function automatic int ref_rem(input int a, input int b);
      return (b == 0) ? a : a % b;
   endfunction

   // One full division: accept, run to done, then return to idle.
   task automatic do_div(input int a, input int b, input bit scramble);
      int lat;
      int busy_seen;
      bus.dividend = WIDTH'(a);
      bus.divisor  = WIDTH'(b);
      bus.start    = 1'b1;
      step();
      bus.start = 1'b0;
      lat       = 1;
      busy_seen = 0;
      while (!bus.done && lat < 40) begin
         if (bus.busy) busy_seen++;
         if (scramble) begin
            bus.dividend = WIDTH'($urandom);
            bus.divisor  = WIDTH'($urandom);
         end
         step();
         lat++;
      end
      check("latency", lat, (b == 0) ? 1 : WIDTH + 1);
      check("busy_cycles", busy_seen, (b == 0) ? 0 : WIDTH);
      check("quotient", int'(bus.quotient), ref_quo(a, b));
      check("remainder", int'(bus.remainder), ref_rem(a, b));
      check("div_by_zero", int'(bus.div_by_zero), (b == 0) ? 1 : 0);
      if (b != 0) begin
         check("invariant", int'(bus.quotient) * b + int'(bus.remainder), a);
         check("rem_lt_div", int'(int'(bus.remainder) < b), 1);
      end
      step();
      check("done_fall", int'(bus.done), 0);
      check("result_hold", int'(bus.quotient), ref_quo(a, b));
   endtask

   initial begin
      int a;
      int b;
      int busy_seen;
      n_checks     = 0;
      n_fail       = 0;
      reset        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      step();
      step();
      check("rst_quotient", int'(bus.quotient), 0);
      check("rst_remainder", int'(bus.remainder), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_dbz", int'(bus.div_by_zero), 0);
      reset = 1'b1;
      step();

      do_div(100, 7, 1'b0);
      do_div(255, 1, 1'b0);
      do_div(255, 255, 1'b0);
      do_div(5, 9, 1'b0);
      do_div(200, 0, 1'b0);
      do_div(200, 3, 1'b0);
      do_div(100, 7, 1'b1);
      do_div(0, 1, 1'b0);
      do_div(254, 255, 1'b0);

      // Reset during the 4th CALC cycle, with start also requested.
      bus.dividend = 8'd250;
      bus.divisor  = 8'd13;
      bus.start    = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      step();
      reset     = 1'b0;
      bus.start = 1'b1;
      step();
      check("midrst_quotient", int'(bus.quotient), 0);
      check("midrst_remainder", int'(bus.remainder), 0);
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_done", int'(bus.done), 0);
      reset     = 1'b1;
      bus.start = 1'b0;
      step();
      check("post_rst_idle", int'(bus.busy), 0);
      do_div(250, 13, 1'b0);

      // Start held through completion must not retrigger.
      bus.dividend = 8'd77;
      bus.divisor  = 8'd5;
      bus.start    = 1'b1;
      step();
      busy_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.busy) busy_seen++;
         step();
      end
      check("hold_busy_cycles", busy_seen, WIDTH);
      check("hold_done", int'(bus.done), 1);
      check("hold_quotient", int'(bus.quotient), 15);
      check("hold_remainder", int'(bus.remainder), 2);
      bus.start = 1'b0;
      step();
      check("hold_release", int'(bus.done), 0);
      do_div(129, 128, 1'b0);

      // Random sweep, with occasional zero and extreme divisors.
      for (int i = 0; i < 300; i++) begin
         a = int'($urandom_range(0, 255));
         case ($urandom_range(0, 7))
            0:       b = 0;
            1:       b = 1;
            2:       b = 255;
            default: b = int'($urandom_range(1, 255));
         endcase
         do_div(a, b, ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
